// File: rtl/gate_exhaustive_checker.sv
// gate_exhaustive_checker
//   Drives every N-bit input vector, in ascending order, into an external gate
//   under test. For each vector it waits SETTLE cycles, then compares the
//   gate's output against a built-in reference function (AND/OR/XOR/NAND
//   reduction). It counts mismatches and records the first failing vector.
//
// Parameters
//   N       number of gate inputs (1..8)
//   MODE    reference function: 0=AND, 1=OR, 2=XOR, 3=NAND
//   SETTLE  cycles from a stim update to its sample edge (1..15)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             begin an exhaustive run (honoured in IDLE/DONE)
//   abort             cancel run / leave DONE (wins over start)
//   dut_y             output of the gate under test
//   stim[N-1:0]       vector driven into the gate
//   exp_y             reference function of stim (combinational)
//   busy / done       high in RUN / DONE
//   pass              high in DONE with zero mismatches
//   err_count[N:0]    mismatches in the current or last run
//   first_fail_vec    stim of the first mismatch
//   first_fail_valid  first_fail_vec has been captured
module gate_exhaustive_checker #(
  parameter int N      = 2,
  parameter int MODE   = 0,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         dut_y,
  output logic [N-1:0] stim,
  output logic         exp_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail_vec,
  output logic         first_fail_valid
);

  localparam logic [N-1:0] LAST_VEC = '1;
  localparam logic [3:0]   RELOAD   = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       launch;
  logic       sample;
  logic       mismatch;

  function automatic logic ref_fn(input logic [N-1:0] v);
    logic r;
    case (MODE)
      1:       r = |v;
      2:       r = ^v;
      3:       r = ~&v;
      default: r = &v;
    endcase
    return r;
  endfunction

  // 2^N mismatches fit in N+1 bits, so this only guards against misuse.
  function automatic logic [N:0] sat_inc(input logic [N:0] c);
    return (c == '1) ? c : c + (N+1)'(1);
  endfunction

  assign exp_y    = ref_fn(stim);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign pass     = (state == S_DONE) && (err_count == '0);
  assign mismatch = sample && (dut_y != exp_y);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    sample    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!abort && start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      S_RUN: begin
        // abort on a sample edge suppresses that sample entirely
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (settle_cnt == 4'd0) begin
          sample = 1'b1;
          if (stim == LAST_VEC) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Results survive abort; only a new launch or reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim             <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (launch) begin
      stim             <= '0;
      settle_cnt       <= RELOAD;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      stim <= '0;
    end else if (sample) begin
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (!first_fail_valid) begin
          first_fail_vec   <= stim;
          first_fail_valid <= 1'b1;
        end
      end
      // the final vector stays on stim while DONE holds the results
      if (stim != LAST_VEC) begin
        stim       <= stim + N'(1);
        settle_cnt <= RELOAD;
      end
    end else if (state == S_RUN) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
module tb_gate_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] abort = '0;
  logic [2:0] rnd = '0;
  logic [2:0] dut_y;
  int         beh [3];
  bit         chk_on = 1'b0;
  int         tests = 0;
  int         fails = 0;

  // three configurations: {N,MODE,SETTLE} = {2,0,1}, {3,2,2}, {1,3,1}
  function automatic int cfg_n(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 1;
  endfunction
  function automatic int cfg_mode(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction
  function automatic int cfg_s(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  logic [1:0] s0, f0;
  logic [2:0] e0;
  logic [2:0] s1, f1;
  logic [3:0] e1;
  logic       s2, f2;
  logic [1:0] e2;
  logic [2:0] xe, bz, dn, ps, fv;

  logic [7:0] d_stim [3];
  logic [7:0] d_ffv  [3];
  logic [8:0] d_err  [3];

  assign d_stim[0] = 8'(s0);
  assign d_stim[1] = 8'(s1);
  assign d_stim[2] = 8'(s2);
  assign d_ffv[0]  = 8'(f0);
  assign d_ffv[1]  = 8'(f1);
  assign d_ffv[2]  = 8'(f2);
  assign d_err[0]  = 9'(e0);
  assign d_err[1]  = 9'(e1);
  assign d_err[2]  = 9'(e2);

  gate_exhaustive_checker #(.N(2), .MODE(0), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .dut_y(dut_y[0]),
    .stim(s0), .exp_y(xe[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(e0), .first_fail_vec(f0), .first_fail_valid(fv[0]));

  gate_exhaustive_checker #(.N(3), .MODE(2), .SETTLE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .dut_y(dut_y[1]),
    .stim(s1), .exp_y(xe[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(e1), .first_fail_vec(f1), .first_fail_valid(fv[1]));

  gate_exhaustive_checker #(.N(1), .MODE(3), .SETTLE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .dut_y(dut_y[2]),
    .stim(s2), .exp_y(xe[2]), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .err_count(e2), .first_fail_vec(f2), .first_fail_valid(fv[2]));

  always #5 clk = ~clk;

  // reference gate function from the count of ones among the n inputs
  function automatic logic ref_fn(input int mode, input int n, input logic [7:0] v);
    int ones;
    ones = 0;
    for (int k = 0; k < n; k++) ones += int'(v[k]);
    case (mode)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  // gate under test: 0 correct, 1 stuck-at-0, 2 OR gate, 3 random
  always_comb begin
    dut_y = '0;
    for (int i = 0; i < 3; i++) begin
      case (beh[i])
        0:       dut_y[i] = ref_fn(cfg_mode(i), cfg_n(i), d_stim[i]);
        1:       dut_y[i] = 1'b0;
        2:       dut_y[i] = |d_stim[i];
        default: dut_y[i] = rnd[i];
      endcase
    end
  end

  // behavioural model: phase 0 idle, 1 run, 2 done; m_t = edges since launch
  int         m_ph  [3];
  int         m_t   [3];
  int         m_err [3];
  logic [7:0] m_ffv [3];
  bit         m_ffval [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      automatic int ph = m_ph[i];
      automatic int t = m_t[i];
      automatic int er = m_err[i];
      automatic logic [7:0] fvv = m_ffv[i];
      automatic bit fvl = m_ffval[i];
      automatic int v;
      if (!rst_n) begin
        ph = 0; t = 0; er = 0; fvv = '0; fvl = 1'b0;
      end else if (ph == 1) begin
        if (abort[i]) begin
          ph = 0;
        end else begin
          t++;
          if (t % cfg_s(i) == 0) begin
            v = t / cfg_s(i) - 1;
            if (dut_y[i] != ref_fn(cfg_mode(i), cfg_n(i), 8'(v))) begin
              er++;
              if (!fvl) begin
                fvv = 8'(v);
                fvl = 1'b1;
              end
            end
            if (v == (1 << cfg_n(i)) - 1) ph = 2;
          end
        end
      end else if (abort[i]) begin
        ph = 0;
      end else if (start[i]) begin
        ph = 1; t = 0; er = 0; fvl = 1'b0;
      end
      m_ph[i]    <= ph;
      m_t[i]     <= t;
      m_err[i]   <= er;
      m_ffv[i]   <= fvv;
      m_ffval[i] <= fvl;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare of every instance against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        automatic int es;
        es = (m_ph[i] == 1) ? m_t[i] / cfg_s(i) :
             (m_ph[i] == 2) ? (1 << cfg_n(i)) - 1 : 0;
        chk($sformatf("stim[%0d]", i), 32'(d_stim[i]), 32'(es));
        chk($sformatf("exp_y[%0d]", i), 32'(xe[i]),
            32'(ref_fn(cfg_mode(i), cfg_n(i), 8'(es))));
        chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(m_ph[i] == 1));
        chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_ph[i] == 2));
        chk($sformatf("pass[%0d]", i), 32'(ps[i]), 32'(m_ph[i] == 2 && m_err[i] == 0));
        chk($sformatf("err[%0d]", i), 32'(d_err[i]), 32'(m_err[i]));
        chk($sformatf("ffv[%0d]", i), 32'(d_ffv[i]), 32'(m_ffv[i]));
        chk($sformatf("ffvalid[%0d]", i), 32'(fv[i]), 32'(m_ffval[i]));
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s stim[%0d]", tag, i), 32'(d_stim[i]), 0);
      chk($sformatf("%s busy[%0d]", tag, i), 32'(bz[i]), 0);
      chk($sformatf("%s done[%0d]", tag, i), 32'(dn[i]), 0);
      chk($sformatf("%s pass[%0d]", tag, i), 32'(ps[i]), 0);
      chk($sformatf("%s err[%0d]", tag, i), 32'(d_err[i]), 0);
      chk($sformatf("%s ffv[%0d]", tag, i), 32'(d_ffv[i]), 0);
      chk($sformatf("%s ffvalid[%0d]", tag, i), 32'(fv[i]), 0);
    end
  endtask

  // lat = number of edges after the launch edge until done is seen
  task automatic run(input int i, output int lat);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    lat = 0;
    while (!dn[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) chk($sformatf("timeout[%0d]", i), 32'(lat), 32'd0);
  endtask

  initial begin
    int lat;
    beh[0] = 0; beh[1] = 0; beh[2] = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // correct AND gate: 4 vectors, done 4 edges after launch
    run(0, lat);
    chk("and_ok lat", 32'(lat), 4);
    chk("and_ok pass", 32'(ps[0]), 1);
    chk("and_ok err", 32'(d_err[0]), 0);
    chk("and_ok stim", 32'(d_stim[0]), 3);

    // stuck-at-0: only vector 3 fails
    beh[0] = 1;
    run(0, lat);
    chk("stuck0 err", 32'(d_err[0]), 1);
    chk("stuck0 ffv", 32'(d_ffv[0]), 3);
    chk("stuck0 pass", 32'(ps[0]), 0);

    // XOR reference vs OR gate, SETTLE=2: vectors 3,5,6 fail
    beh[1] = 2;
    run(1, lat);
    chk("xor lat", 32'(lat), 16);
    chk("xor err", 32'(d_err[1]), 3);
    chk("xor ffv", 32'(d_ffv[1]), 3);

    // single-input NAND, then a restart straight from DONE
    run(2, lat);
    chk("nand lat", 32'(lat), 2);
    chk("nand pass", 32'(ps[2]), 1);
    run(2, lat);
    chk("nand rerun lat", 32'(lat), 2);
    chk("nand rerun pass", 32'(ps[2]), 1);
    chk("nand rerun err", 32'(d_err[2]), 0);

    // start ignored mid-run, abort on the vector-2 sample edge
    beh[0] = 2;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk);
    chk("ign stim1", 32'(d_stim[0]), 1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("ign stim2", 32'(d_stim[0]), 2);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort stim", 32'(d_stim[0]), 0);
    chk("abort done", 32'(dn[0]), 0);
    chk("abort busy", 32'(bz[0]), 0);
    chk("abort err", 32'(d_err[0]), 1);
    chk("abort ffv", 32'(d_ffv[0]), 1);
    chk("abort ffvalid", 32'(fv[0]), 1);

    // asynchronous reset between edges mid-run; start ignored while held
    beh[1] = 0;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async");
    start[1] = 1'b1;
    @(posedge clk);
    #1 chk("rst start ignored", 32'(bz[1]), 0);
    @(negedge clk);
    start[1] = 1'b0;
    rst_n = 1'b1;
    run(1, lat);
    chk("post rst lat", 32'(lat), 16);
    chk("post rst pass", 32'(ps[1]), 1);

    // randomized gates, start noise and occasional aborts
    for (int it = 0; it < 30; it++) begin
      automatic int i;
      i = $urandom_range(0, 2);
      beh[i] = $urandom_range(0, 3);
      @(negedge clk); start[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0;
      for (int c = 0; c < 80 && m_ph[i] == 1; c++) begin
        rnd = 3'($urandom);
        start[i] = ($urandom_range(0, 3) == 0);
        abort[i] = ($urandom_range(0, 29) == 0);
        @(negedge clk);
      end
      start = '0;
      abort = '0;
      repeat (2) @(negedge clk);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_exhaustive_checker.md
GATE_EXHAUSTIVE_CHECKER -- requirements
Module: gate_exhaustive_checker

Interface
REQ-001: Parameter N, default 2, SHALL set the number of gate inputs exercised; legal range 1..8.
REQ-002: Parameter MODE, default 0, SHALL select the reference function: 0=AND, 1=OR, 2=XOR, 3=NAND (reduction over all N inputs).
REQ-003: Parameter SETTLE, default 1, SHALL set the cycles from a stimulus update to its sample edge; legal range 1..15.
REQ-004: clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005: rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006: start  input  1  SHALL request an exhaustive run; sampled only in IDLE or DONE.
REQ-007: abort  input  1  SHALL cancel a run in progress.
REQ-008: dut_y  input  1  SHALL carry the DUT output under test.
REQ-009: stim  output  N  SHALL drive the DUT inputs.
REQ-010: exp_y  output  1  SHALL present the reference function of the current stim, combinationally.
REQ-011: busy  output  1  SHALL be high while in RUN.
REQ-012: done  output  1  SHALL be high while in DONE.
REQ-013: pass  output  1  SHALL be high in DONE when err_count==0; low otherwise.
REQ-014: err_count  output  N+1  SHALL count mismatches in the current or last run.
REQ-015: first_fail_vec  output  N  SHALL hold the stim value of the first mismatch.
REQ-016: first_fail_valid  output  1  SHALL be high once first_fail_vec is captured.

Function
REQ-017: FSM SHALL have the states IDLE, RUN and DONE.
REQ-018: IDLE + start=1 at edge E0 -> RUN; SHALL set stim=0, err_count=0, first_fail_valid=0, and settle counter=SETTLE-1.
REQ-019: In RUN, the settle counter SHALL decrement each edge; at the edge where it equals 0, the block SHALL sample dut_y and compare it with exp_y.
REQ-020: Vector v SHALL be sampled at edge E0+(v+1)*SETTLE.
REQ-021: On mismatch, err_count SHALL increment; if first_fail_valid==0, first_fail_vec SHALL be set to stim and first_fail_valid to 1, in the same edge.
REQ-022: After a sample with stim < 2^N-1, stim SHALL increment by 1 and the counter SHALL reload to SETTLE-1.
REQ-023: After a sample with stim == 2^N-1 (all ones), the FSM SHALL go to DONE, with stim held and the last comparison included in err_count and pass; done SHALL be first high after edge E0+2^N*SETTLE.
REQ-024: err_count SHALL NOT wrap: its width N+1 holds the maximum 2^N mismatches.
REQ-025: start in RUN SHALL be ignored.
REQ-026: DONE SHALL hold all results until start or abort; start in DONE SHALL restart exactly as from IDLE (REQ-018).
REQ-027: abort in RUN or DONE SHALL go to IDLE: stim=0, busy=0, done=0, pass=0; err_count and first_fail_* SHALL be retained.
REQ-028: abort and start in the same cycle SHALL resolve to abort.
REQ-029: abort SHALL take effect even on a sample edge; that sample SHALL NOT be counted.

Reset
REQ-030: rst_n=0 SHALL immediately, without a clock, force IDLE with stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0 and first_fail_valid=0.
REQ-031: Reset assertion mid-run SHALL discard the run; the first start after release SHALL begin a fresh run.
REQ-032: While rst_n=0, start and abort SHALL be ignored.

Verification
REQ-033: N=2, MODE=0, SETTLE=1, dut_y=exp_y-correct AND model; start at E0 -> stim 0,1,2,3 on consecutive cycles, done at E0+4, pass=1, err_count=0.
REQ-034: N=2, MODE=0, dut_y stuck at 0 -> err_count=1, first_fail_vec=3, pass=0.
REQ-035: N=3, MODE=2, SETTLE=2, dut_y=OR of stim -> err_count=3 (vectors 3,5,6), first_fail_vec=3, done at E0+16.
REQ-036: N=1, MODE=3, dut_y=~stim -> 2 vectors, pass=1; rerun via start in DONE -> identical results and timing.
REQ-037: N=2 run; start pulsed at vector 1 -> no effect; abort at vector 2 -> IDLE, stim=0, done=0, err_count retained.
REQ-038: rst_n driven low between clock edges mid-run -> all outputs 0 before the next edge; a new start after release completes normally.
